up_control: RTL and testbench

- Sequencing control unit for the 8-bit nibble-instruction datapath.
- Fetches one 4-bit instruction per step from byte-wide memory through the datapath's address path.
- Decodes the instruction and drives the datapath strobes: op, ir_we, pc_we, rb_sel_in, rb_we, sp_we.
- Owns the memory read/write handshake, a wait-state timeout and halt/error status.

---
 rtl/up_control.sv | 184 ++++++++++++++++++
 tb/tb_up_control.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/up_control.sv
// Sequencing controller for the nibble-instruction datapath: fetch/decode/execute FSM,
// memory read/write handshake with wait-state timeout, halt and sticky error status.
module up_control #(
  parameter int ACK_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] ir,
  input  logic       z,
  input  logic       mem_ack,
  output logic [4:0] op,
  output logic       ir_we,
  output logic       pc_we,
  output logic [2:0] rb_sel_in,
  output logic       rb_we,
  output logic       sp_we,
  output logic       mem_addr_we,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       halted,
  output logic       err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FA   = 3'd1;
  localparam logic [2:0] S_FR   = 3'd2;
  localparam logic [2:0] S_PI   = 3'd3;
  localparam logic [2:0] S_EX   = 3'd4;
  localparam logic [2:0] S_LR   = 3'd5;
  localparam logic [2:0] S_SW   = 3'd6;
  localparam logic [2:0] S_HALT = 3'd7;

  localparam bit              TO_EN   = (ACK_TIMEOUT > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT > 0 ? ACK_TIMEOUT - 1 : 0);

  logic [2:0]      state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
  logic            wait_st;
  logic            timeout;

  assign wait_st = (state_q == S_FR) || (state_q == S_LR) || (state_q == S_SW);
  // The limit cycle is the last one in which mem_ack may still complete normally.
  assign timeout = TO_EN && wait_st && !mem_ack && (to_cnt_q == TO_LAST);

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    to_cnt_d = '0;
    if (wait_st && !mem_ack) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
    case (state_q)
      S_IDLE: if (start) state_d = S_FA;
      S_FA:   state_d = S_FR;
      S_FR:   if (mem_ack) state_d = S_PI;
      S_PI:   state_d = S_EX;
      S_EX: begin
        case (ir)
          4'h7:    state_d = S_LR;
          4'h8:    state_d = S_SW;
          4'hF:    state_d = S_HALT;
          default: state_d = S_FA;
        endcase
      end
      S_LR, S_SW: if (mem_ack) state_d = S_FA;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    if (timeout) begin
      state_d = S_HALT;
      err_d   = 1'b1;
    end
  end

  always_comb begin
    op          = 5'b00000;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    rb_sel_in   = 3'b000;
    rb_we       = 1'b0;
    sp_we       = 1'b0;
    mem_addr_we = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    halted      = 1'b0;
    case (state_q)
      S_FA: begin
        op          = 5'b10100;
        mem_addr_we = 1'b1;
      end
      S_FR: begin
        mem_rd = 1'b1;
        ir_we  = mem_ack;
      end
      S_PI: begin
        op    = 5'b10101;
        pc_we = 1'b1;
      end
      S_EX: begin
        case (ir)
          4'h0, 4'h1, 4'h2, 4'h3: begin
            op        = {3'b000, ir[1:0]};
            rb_sel_in = 3'b101;
            rb_we     = 1'b1;
          end
          4'h4: begin
            op        = 5'b00100;
            rb_sel_in = 3'b100;
          end
          4'h5: begin
            op        = 5'b00101;
            rb_sel_in = 3'b110;
          end
          4'h6: begin
            op        = 5'b00110;
            rb_sel_in = 3'b111;
          end
          4'h7: begin
            op          = 5'b10110;
            mem_addr_we = 1'b1;
          end
          4'h8: begin
            op          = 5'b11001;
            mem_addr_we = 1'b1;
          end
          4'h9: begin
            op    = 5'b10110;
            sp_we = 1'b1;
          end
          4'hA: begin
            op        = 5'b10000;
            rb_sel_in = 3'b100;
            rb_we     = 1'b1;
          end
          4'hB: begin
            op        = 5'b10001;
            rb_sel_in = 3'b100;
            rb_we     = 1'b1;
          end
          4'hC: begin
            op    = 5'b10110;
            pc_we = 1'b1;
          end
          4'hD: begin
            if (z) begin
              op    = 5'b10110;
              pc_we = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_LR: begin
        mem_rd    = 1'b1;
        rb_sel_in = 3'b001;
        rb_we     = mem_ack;
      end
      S_SW: begin
        op     = 5'b10110;
        mem_wr = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_up_control.sv
// Bench for up_control: instruction-level expected strobe traces, random programs,
// reset, wait-state and timeout cases (second instance with the timeout disabled).
module tb_up_control;

  logic       clk = 1'b0;
  logic       rst, start, z, mem_ack;
  logic [3:0] ir;

  logic [4:0] op, op0;
  logic       ir_we, pc_we, rb_we, sp_we, mem_addr_we, mem_rd, mem_wr, halted, err;
  logic       ir_we0, pc_we0, rb_we0, sp_we0, mem_addr_we0, mem_rd0, mem_wr0, halted0, err0;
  logic [2:0] rb_sel_in, rb_sel_in0;

  up_control #(.ACK_TIMEOUT(15), .TO_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .ir(ir), .z(z), .mem_ack(mem_ack),
    .op(op), .ir_we(ir_we), .pc_we(pc_we), .rb_sel_in(rb_sel_in), .rb_we(rb_we),
    .sp_we(sp_we), .mem_addr_we(mem_addr_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .halted(halted), .err(err)
  );

  up_control #(.ACK_TIMEOUT(0), .TO_W(4)) dut0 (
    .clk(clk), .rst(rst), .start(start), .ir(ir), .z(z), .mem_ack(mem_ack),
    .op(op0), .ir_we(ir_we0), .pc_we(pc_we0), .rb_sel_in(rb_sel_in0), .rb_we(rb_we0),
    .sp_we(sp_we0), .mem_addr_we(mem_addr_we0), .mem_rd(mem_rd0), .mem_wr(mem_wr0),
    .halted(halted0), .err(err0)
  );

  always #5 clk = ~clk;

  logic [16:0] o_vec, o0_vec;
  assign o_vec  = {op, ir_we, pc_we, rb_sel_in, rb_we, sp_we, mem_addr_we, mem_rd, mem_wr, halted, err};
  assign o0_vec = {op0, ir_we0, pc_we0, rb_sel_in0, rb_we0, sp_we0, mem_addr_we0, mem_rd0, mem_wr0,
                   halted0, err0};

  int   nchk = 0;
  int   nfail = 0;
  logic [3:0] cur_ir = 4'h0;
  logic cur_z = 1'b0;
  logic cur_start = 1'b0;
  logic noise = 1'b0;
  logic chk0 = 1'b1;

  // Expected output vector in the same field order as o_vec.
  function automatic logic [16:0] v(input logic [4:0] op_, input logic irw, input logic pcw,
                                    input logic [2:0] rbs, input logic rbw, input logic spw,
                                    input logic maw, input logic rd, input logic wr,
                                    input logic hlt, input logic er);
    return {op_, irw, pcw, rbs, rbw, spw, maw, rd, wr, hlt, er};
  endfunction

  // Strobes the execute cycle must show for each instruction.
  function automatic logic [16:0] ex_vec(input logic [3:0] ins, input logic zz);
    case (ins)
      4'h0, 4'h1, 4'h2, 4'h3: return v(5'(ins), 0, 0, 3'b101, 1, 0, 0, 0, 0, 0, 0);
      4'h4: return v(5'b00100, 0, 0, 3'b100, 0, 0, 0, 0, 0, 0, 0);
      4'h5: return v(5'b00101, 0, 0, 3'b110, 0, 0, 0, 0, 0, 0, 0);
      4'h6: return v(5'b00110, 0, 0, 3'b111, 0, 0, 0, 0, 0, 0, 0);
      4'h7: return v(5'b10110, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0, 0);
      4'h8: return v(5'b11001, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0, 0);
      4'h9: return v(5'b10110, 0, 0, 3'b000, 0, 1, 0, 0, 0, 0, 0);
      4'hA: return v(5'b10000, 0, 0, 3'b100, 1, 0, 0, 0, 0, 0, 0);
      4'hB: return v(5'b10001, 0, 0, 3'b100, 1, 0, 0, 0, 0, 0, 0);
      4'hC: return v(5'b10110, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0);
      4'hD: return zz ? v(5'b10110, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0) : 17'd0;
      default: return 17'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, check outputs 1 time unit later.
  task automatic step(input string tag, input logic [16:0] exp, input logic ack);
    @(negedge clk);
    mem_ack = ack;
    ir      = cur_ir;
    z       = cur_z;
    start   = cur_start | (noise & 1'($urandom_range(0, 1)));
    #1;
    chk(tag, o_vec, exp);
    if (chk0) chk({tag, "/t0"}, o0_vec, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; mem_ack = 1'b0; cur_start = 1'b0;
    #1;
    chk("reset", o_vec, 17'd0);
    chk("reset/t0", o0_vec, 17'd0);
    rst = 1'b0;
    chk0 = 1'b1;
  endtask

  task automatic begin_prog();
    cur_start = 1'b1;
    step("IDLE_start", 17'd0, 1'b0);
    cur_start = 1'b0;
  endtask

  task automatic fetch(input logic [3:0] ins, input int fw, input logic zz);
    step("FA", v(5'b10100, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0, 0), 1'b0);
    repeat (fw) step("FR_wait", v(5'b00000, 0, 0, 3'b000, 0, 0, 0, 1, 0, 0, 0), 1'b0);
    step("FR_ack", v(5'b00000, 1, 0, 3'b000, 0, 0, 0, 1, 0, 0, 0), 1'b1);
    cur_ir = ins;
    cur_z  = zz;
    step("PI", v(5'b10101, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    step("EX", ex_vec(ins, zz), 1'b0);
  endtask

  task automatic do_instr(input logic [3:0] ins, input int fw, input int dw, input logic zz);
    fetch(ins, fw, zz);
    if (ins == 4'h7) begin
      repeat (dw) step("LR_wait", v(5'b00000, 0, 0, 3'b001, 0, 0, 0, 1, 0, 0, 0), 1'b0);
      step("LR_ack", v(5'b00000, 0, 0, 3'b001, 1, 0, 0, 1, 0, 0, 0), 1'b1);
    end else if (ins == 4'h8) begin
      repeat (dw) step("SW_wait", v(5'b10110, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 0), 1'b0);
      step("SW_ack", v(5'b10110, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 0), 1'b1);
    end else if (ins == 4'hF) begin
      step("HALT", v(5'b00000, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1, 0), 1'b0);
    end
  endtask

  logic [16:0] sw_wait_v, fr_wait_v, halt_err_v;
  logic [3:0]  rnd_ins;

  initial begin
    rst = 1'b1; start = 1'b0; ir = 4'h0; z = 1'b0; mem_ack = 1'b0;
    sw_wait_v  = v(5'b10110, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 0);
    fr_wait_v  = v(5'b00000, 0, 0, 3'b000, 0, 0, 0, 1, 0, 0, 0);
    halt_err_v = v(5'b00000, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1, 1);
    do_reset();

    // Reset in the middle of a fetch wait drops the read at once.
    begin_prog();
    step("FA", v(5'b10100, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0, 0), 1'b0);
    step("FR_wait", fr_wait_v, 1'b0);
    step("FR_wait", fr_wait_v, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_fr", o_vec, 17'd0);
    chk("rst_mid_fr/t0", o0_vec, 17'd0);
    @(negedge clk);
    rst = 1'b0;
    begin_prog();

    // A, B, ADD, HALT with zero-wait memory.
    do_instr(4'hA, 0, 0, 1'b0);
    do_instr(4'hB, 0, 0, 1'b0);
    do_instr(4'h0, 0, 0, 1'b0);
    do_instr(4'hF, 0, 0, 1'b0);
    cur_start = 1'b1;
    repeat (3) step("HALT_hold", v(5'b00000, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1, 0), 1'b0);
    cur_start = 1'b0;

    // LD with delayed ack, then branches and ack exactly at the timeout limit.
    do_reset();
    begin_prog();
    do_instr(4'h7, 0, 3, 1'b0);
    do_instr(4'hE, 0, 0, 1'b0);
    do_instr(4'hD, 0, 0, 1'b1);
    do_instr(4'hD, 1, 0, 1'b0);
    do_instr(4'hC, 0, 0, 1'b0);
    do_instr(4'h7, 14, 14, 1'b0);
    do_instr(4'h8, 14, 14, 1'b0);
    do_instr(4'h8, 0, 2, 1'b1);

    // Random programs with random wait states and start noise.
    noise = 1'b1;
    for (int n = 0; n < 80; n++) begin
      rnd_ins = 4'($urandom_range(0, 14));
      do_instr(rnd_ins, $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end
    do_instr(4'hF, 0, 0, 1'b0);
    noise = 1'b0;

    // STS never acknowledged: timeout versus disabled timeout.
    do_reset();
    begin_prog();
    fetch(4'h8, 0, 1'b0);
    repeat (15) step("SW_wait", sw_wait_v, 1'b0);
    chk0 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step("SW_timeout_halt", halt_err_v, 1'b0);
      chk("t0_still_waiting", o0_vec, sw_wait_v);
    end
    do_reset();

    // Fetch never acknowledged.
    begin_prog();
    step("FA", v(5'b10100, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0, 0), 1'b0);
    repeat (15) step("FR_wait", fr_wait_v, 1'b0);
    chk0 = 1'b0;
    step("FR_timeout_halt", halt_err_v, 1'b0);
    chk("t0_fr_waiting", o0_vec, fr_wait_v);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
